// File: rtl/demultiplexer4_tdm.sv
// Receive side of a 4-slot TDM link: de-interleaves a Sync-framed sample stream
// into a registered 4-slot word, with an addressed mode for direct slot writes.
module demultiplexer4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   D,
  input  logic               Valid,
  input  logic               Sync,
  input  logic               Mode,
  input  logic [1:0]         Address,
  output logic [4*WIDTH-1:0] Y,
  output logic [1:0]         Slot,
  output logic               FrameValid,
  output logic               Error
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_slot, w_slot_nxt;
  logic [3*WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [4*WIDTH-1:0]   r_y, w_y_nxt;
  logic                 r_fv, w_fv_nxt;
  logic                 r_err, w_err_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_shadow_nxt = r_shadow;
    w_y_nxt      = r_y;
    w_fv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;

    if (!Mode) begin
      // Addressed mode abandons any partial frame; scan restarts from HUNT.
      w_state_nxt = HUNT;
      w_slot_nxt  = '0;
      if (Valid) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (Address == 2'(i)) w_y_nxt[i*WIDTH +: WIDTH] = D;
        end
      end
    end else if (Valid) begin
      case (r_state)
        HUNT: begin
          if (Sync) begin
            w_shadow_nxt[WIDTH-1:0] = D;
            w_slot_nxt              = 2'd1;
            w_state_nxt             = RUN;
          end
        end
        RUN: begin
          if (Sync) begin
            // A Sync at any slot other than 0 drops the partial frame and resyncs.
            w_err_nxt               = (r_slot != 2'd0);
            w_shadow_nxt[WIDTH-1:0] = D;
            w_slot_nxt              = 2'd1;
          end else begin
            case (r_slot)
              2'd0: begin
                w_err_nxt   = 1'b1;
                w_state_nxt = HUNT;
                w_slot_nxt  = '0;
              end
              2'd1: begin
                w_shadow_nxt[WIDTH +: WIDTH] = D;
                w_slot_nxt                   = 2'd2;
              end
              2'd2: begin
                w_shadow_nxt[2*WIDTH +: WIDTH] = D;
                w_slot_nxt                     = 2'd3;
              end
              default: begin
                w_y_nxt    = {D, r_shadow};
                w_fv_nxt   = 1'b1;
                w_slot_nxt = '0;
              end
            endcase
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_slot_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= HUNT;
      r_slot   <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_shadow <= w_shadow_nxt;
      r_y      <= w_y_nxt;
      r_fv     <= w_fv_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign Y          = r_y;
  assign Slot       = r_slot;
  assign FrameValid = r_fv;
  assign Error      = r_err;

endmodule
